// File: rtl/regfile_wr_arbiter.sv
// Two-source write-port arbiter for regFile: per-source FIFOs, round-robin issue and a per-register
// pending-write scoreboard. Define REGFILE_ARB_STATS_EN to enable the saturating grant counters.
module regfile_wr_arbiter #(
    parameter int unsigned registerSize  = 16,
    parameter int unsigned vectorSize    = 4,
    parameter int unsigned selectionBits = 4,
    parameter int unsigned FIFO_DEPTH    = 2
) (
    input  logic                                clk,
    input  logic                                reset,
    input  logic                                alu_valid,
    output logic                                alu_ready,
    input  logic                                alu_vec,
    input  logic [selectionBits-1:0]            alu_reg,
    input  logic [vectorSize*registerSize-1:0]  alu_data,
    input  logic                                mem_valid,
    output logic                                mem_ready,
    input  logic                                mem_vec,
    input  logic [selectionBits-1:0]            mem_reg,
    input  logic [vectorSize*registerSize-1:0]  mem_data,
    input  logic                                wr_stall,
    output logic                                regWrEnSc,
    output logic                                regWrEnVec,
    output logic [selectionBits-1:0]            regToWrite,
    output logic [vectorSize*registerSize-1:0]  dataIn,
    output logic [2**selectionBits-1:0]         pending,
    output logic [15:0]                         alu_grants,
    output logic [15:0]                         mem_grants
);

    localparam int unsigned DataW   = vectorSize * registerSize;
    localparam int unsigned NumRegs = 2 ** selectionBits;
    localparam int unsigned PtrW    = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned CntW    = $clog2(FIFO_DEPTH + 1);
    localparam int unsigned ScW     = $clog2(2 * FIFO_DEPTH + 1);

    typedef struct packed {
        logic                     vec;
        logic [selectionBits-1:0] dst;
        logic [DataW-1:0]         data;
    } wrEntryT;

    // Source index 0 is the ALU, 1 is the load unit.
    wrEntryT          srcEntry [2];
    wrEntryT          fifoMem  [2][FIFO_DEPTH];
    logic [PtrW-1:0]  wrPtr    [2];
    logic [PtrW-1:0]  rdPtr    [2];
    logic [CntW-1:0]  fifoCnt  [2];
    logic [1:0]       srcValid;
    logic [1:0]       srcReady;
    logic [1:0]       notEmpty;
    logic [1:0]       push;
    logic [1:0]       pop;
    logic             issue;
    logic             grantMem;
    logic             lastMem;
    wrEntryT          head;
    logic [ScW-1:0]   scCnt    [NumRegs];

    always_comb begin
        srcEntry[0] = '{vec: alu_vec, dst: alu_reg, data: alu_data};
        srcEntry[1] = '{vec: mem_vec, dst: mem_reg, data: mem_data};
        srcValid    = {mem_valid, alu_valid};
        for (int s = 0; s < 2; s++) begin
            notEmpty[s] = (fifoCnt[s] != '0);
            srcReady[s] = (fifoCnt[s] != CntW'(FIFO_DEPTH));
            push[s]     = srcValid[s] && srcReady[s];
        end
        alu_ready = srcReady[0];
        mem_ready = srcReady[1];
    end

    // Heads come from registered counts, so an entry pushed this edge cannot be popped this edge.
    always_comb begin
        issue    = !wr_stall && (notEmpty != 2'b00);
        grantMem = notEmpty[1] && (!notEmpty[0] || !lastMem);
        pop[0]   = issue && !grantMem;
        pop[1]   = issue && grantMem;
        head     = grantMem ? fifoMem[1][rdPtr[1]] : fifoMem[0][rdPtr[0]];
    end

    always_ff @(posedge clk) begin
        for (int s = 0; s < 2; s++) begin
            if (push[s]) begin
                fifoMem[s][wrPtr[s]] <= srcEntry[s];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int s = 0; s < 2; s++) begin
                wrPtr[s]   <= '0;
                rdPtr[s]   <= '0;
                fifoCnt[s] <= '0;
            end
        end else begin
            for (int s = 0; s < 2; s++) begin
                if (push[s]) wrPtr[s] <= wrPtr[s] + PtrW'(1);
                if (pop[s])  rdPtr[s] <= rdPtr[s] + PtrW'(1);
                fifoCnt[s] <= fifoCnt[s] + CntW'(push[s]) - CntW'(pop[s]);
            end
        end
    end

    // lastMem = 1 means the load unit won the previous issue; reset favours the ALU.
    always_ff @(posedge clk) begin
        if (reset) begin
            lastMem    <= 1'b1;
            regWrEnSc  <= 1'b0;
            regWrEnVec <= 1'b0;
            regToWrite <= '0;
            dataIn     <= '0;
        end else begin
            regWrEnSc  <= issue && !head.vec;
            regWrEnVec <= issue && head.vec;
            if (issue) begin
                lastMem    <= grantMem;
                regToWrite <= head.dst;
                dataIn     <= head.vec ? head.data : DataW'(head.data[registerSize-1:0]);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int r = 0; r < NumRegs; r++) begin
                scCnt[r] <= '0;
            end
        end else begin
            for (int r = 0; r < NumRegs; r++) begin
                scCnt[r] <= scCnt[r]
                          + ScW'(push[0] && (alu_reg == selectionBits'(r)))
                          + ScW'(push[1] && (mem_reg == selectionBits'(r)))
                          - ScW'(issue && (head.dst == selectionBits'(r)));
            end
        end
    end

    always_comb begin
        pending = '0;
        for (int r = 0; r < NumRegs; r++) begin
            pending[r] = (scCnt[r] != '0);
        end
    end

`ifdef REGFILE_ARB_STATS_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            alu_grants <= '0;
            mem_grants <= '0;
        end else begin
            if (pop[0] && (alu_grants != 16'hFFFF)) alu_grants <= alu_grants + 16'd1;
            if (pop[1] && (mem_grants != 16'hFFFF)) mem_grants <= mem_grants + 16'd1;
        end
    end
`else
    assign alu_grants = '0;
    assign mem_grants = '0;
`endif

endmodule
